// File: rtl/iob_fifo_tdp_ctrl_pkg.sv
// Purpose : shared sizing helpers for the TDP-RAM backed FIFO controller.
// Latency : n/a (types and constant functions only).
// Backpr. : n/a.
package iob_fifo_tdp_ctrl_pkg;

    // Occupancy has to represent 0..2**addrW inclusive, so one bit wider than the pointers.
    function automatic int fifoLevelW(input int addrW);
        return addrW + 1;
    endfunction

    // Per-cycle accept decision, handy for the level update case statement.
    typedef enum logic [1:0] {
        ACC_NONE  = 2'b00,
        ACC_READ  = 2'b01,
        ACC_WRITE = 2'b10,
        ACC_BOTH  = 2'b11
    } acc_t;

endpackage

// File: rtl/iob_fifo_tdp_ctrl.sv
// Purpose : pointer/occupancy controller for a FIFO stored in one iob_ram_tdp
//           (port A write-only, port B read-only).
// Latency : read data valid 1 cycle after an accepted read (registered RAM read).
// Backpr. : w_full rejects writes (w_ovf pulse), r_empty rejects reads (r_unf pulse);
//           one write and one read per cycle sustained.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   w_en/w_data/w_full/w_ovf producer side
//   r_en/r_data/r_valid/r_empty/r_unf consumer side
//   level                    occupancy 0..2**ADDR_W
//   ext_mem_*                RAM port A (write) and port B (read) drive/return
module iob_fifo_tdp_ctrl
    import iob_fifo_tdp_ctrl_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int ADDR_W  = 4,
    localparam int LEVEL_W = fifoLevelW(ADDR_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               w_en,
    input  logic [DATA_W-1:0]  w_data,
    output logic               w_full,
    output logic               w_ovf,
    input  logic               r_en,
    output logic               r_empty,
    output logic               r_unf,
    output logic [DATA_W-1:0]  r_data,
    output logic               r_valid,
    output logic [LEVEL_W-1:0] level,
    output logic               ext_mem_w_en,
    output logic [ADDR_W-1:0]  ext_mem_w_addr,
    output logic [DATA_W-1:0]  ext_mem_w_data,
    output logic               ext_mem_r_en,
    output logic [ADDR_W-1:0]  ext_mem_r_addr,
    input  logic [DATA_W-1:0]  ext_mem_r_data
);

    localparam logic [LEVEL_W-1:0] DEPTH = LEVEL_W'(1) << ADDR_W;

    logic [ADDR_W-1:0] wPtr;
    logic [ADDR_W-1:0] rPtr;
    logic              wrAcc;
    logic              rdAcc;
    acc_t              accSel;

    // Flags decode only registered level, so no request input reaches them.
    assign w_full  = (level == DEPTH);
    assign r_empty = (level == '0);

    assign wrAcc  = w_en & ~w_full;
    assign rdAcc  = r_en & ~r_empty;
    assign accSel = acc_t'({wrAcc, rdAcc});

    // A write needs level <= depth-1 and a read needs level >= 1, so whenever
    // both are accepted the pointers differ and the RAM ports never collide.
    assign ext_mem_w_en   = wrAcc;
    assign ext_mem_w_addr = wPtr;
    assign ext_mem_w_data = w_data;
    assign ext_mem_r_en   = rdAcc;
    assign ext_mem_r_addr = rPtr;

    // RAM output register holds between reads, so no local capture is needed.
    assign r_data = ext_mem_r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            wPtr    <= '0;
            rPtr    <= '0;
            level   <= '0;
            r_valid <= 1'b0;
            w_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_valid <= rdAcc;
            w_ovf   <= w_en & w_full;
            r_unf   <= r_en & r_empty;
            if (wrAcc) wPtr <= wPtr + 1'b1;   // wraps modulo depth
            if (rdAcc) rPtr <= rPtr + 1'b1;
            case (accSel)
                ACC_WRITE: level <= level + 1'b1;
                ACC_READ:  level <= level - 1'b1;
                default:   level <= level;
            endcase
        end
    end

endmodule
